// File: rtl/fft_output_reorder.sv
// fft_output_reorder: ping-pong frame buffer that emits 8-point FFT results in bit-reversed order, rounded and saturated
module fft_output_reorder #(
  parameter int DATA_WIDTH = 50,
  parameter int OUT_WIDTH  = 32,
  parameter int FRAME      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] signal_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [OUT_WIDTH-1:0]  signal_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  last_o,
  output logic                  sat_o
);
  localparam int IW = DATA_WIDTH / 2;
  localparam int OW = OUT_WIDTH / 2;
  localparam int D  = IW - OW;
  localparam int AW = $clog2(FRAME);
  localparam logic signed [IW:0] HALF = (IW+1)'(1) <<< (D - 1);
  localparam logic signed [IW:0] MAXV = (IW+1)'((1 << (OW - 1)) - 1);
  localparam logic signed [IW:0] MINV = -MAXV - (IW+1)'(1);
  localparam logic [AW-1:0] LAST = AW'(FRAME - 1);

  // Round half up by D bits, then clip to the output range; MSB of the result flags a clip
  function automatic logic [OW:0] rnd(input logic [IW-1:0] x);
    logic signed [IW:0] y;
    y = ($signed({x[IW-1], x}) + HALF) >>> D;
    return (y > MAXV) ? {1'b1, MAXV[OW-1:0]} : (y < MINV) ? {1'b1, MINV[OW-1:0]} : {1'b0, y[OW-1:0]};
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [2][FRAME];
  logic                  wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [AW-1:0]         wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, rd_addr;
  logic [1:0]            full_q, full_d;
  logic                  valid_q, valid_d, last_q, last_d, sat_q, sat_d;
  logic [OUT_WIDTH-1:0]  sig_q, sig_d;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [OW:0]           re_r, im_r;
  logic                  wr_en, ld, wr_last, rd_last;

  assign ready_o  = !full_q[wr_bank_q];
  assign wr_en    = valid_i && ready_o;
  assign ld       = full_q[rd_bank_q] && (!valid_q || ready_i);
  assign wr_last  = wr_cnt_q == LAST;
  assign rd_last  = rd_cnt_q == LAST;
  assign rd_word  = mem_q[rd_bank_q][rd_addr];
  assign re_r     = rnd(rd_word[DATA_WIDTH-1:IW]);
  assign im_r     = rnd(rd_word[IW-1:0]);
  assign signal_o = sig_q;
  assign valid_o  = valid_q;
  assign last_o   = last_q;
  assign sat_o    = sat_q;

  // Read address is the bit-reversed read count, giving natural frequency order
  always_comb begin
    rd_addr = '0;
    for (int i = 0; i < AW; i++) rd_addr[i] = rd_cnt_q[AW-1-i];
  end

  // Next state: a bank fills on the last write and frees on the last read; both may happen on one edge
  always_comb begin
    wr_cnt_d  = wr_en ? wr_cnt_q + AW'(1) : wr_cnt_q;
    wr_bank_d = wr_bank_q ^ (wr_en && wr_last);
    rd_cnt_d  = ld ? rd_cnt_q + AW'(1) : rd_cnt_q;
    rd_bank_d = rd_bank_q ^ (ld && rd_last);
    full_d    = full_q;
    if (wr_en && wr_last) full_d[wr_bank_q] = 1'b1;
    if (ld && rd_last) full_d[rd_bank_q] = 1'b0;
    valid_d   = ld || (valid_q && !ready_i);
    last_d    = ld ? rd_last : last_q && !ready_i;
    sat_d     = ld ? re_r[OW] || im_r[OW] : sat_q && !ready_i;
    sig_d     = ld ? {re_r[OW-1:0], im_r[OW-1:0]} : sig_q;
  end

  // Sample storage; contents survive reset because the full flags gate every read
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_bank_q][wr_cnt_q] <= signal_i;
  end

  // Control and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      full_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      sat_q     <= 1'b0;
      sig_q     <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      full_q    <= full_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      sat_q     <= sat_d;
      sig_q     <= sig_d;
    end
  end
endmodule

// File: tb/tb_fft_output_reorder.sv
// tb_fft_output_reorder: directed and randomised checks of reorder, rounding, backpressure and reset
module tb_fft_output_reorder;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [49:0] signal_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] signal_o;
  logic        valid_o;
  logic        ready_i;
  logic        last_o;
  logic        sat_o;

  fft_output_reorder #(.DATA_WIDTH(50), .OUT_WIDTH(32), .FRAME(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .signal_i(signal_i), .valid_i(valid_i), .ready_o(ready_o),
    .signal_o(signal_o), .valid_o(valid_o), .ready_i(ready_i), .last_o(last_o), .sat_o(sat_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_chk = 0, n_fail = 0, acc = 0, outs = 0, in_cnt = 0;
  bit          auto_exp = 0;
  logic [49:0] src_q[$];
  logic [33:0] exp_q[$];
  logic [49:0] fbuf[8];
  int          ord[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  int          ri[8]  = '{767, 768, -768, 16777215, 0, 255, 256, 1000};
  int          ii[8]  = '{0, 0, 0, 0, -16777216, -257, -256, -1000};
  int          er[8]  = '{1, 0, -1, 1, 2, 0, 32767, 2};
  int          ei[8]  = '{0, -32768, 0, 0, 0, -1, 0, -2};
  bit          es[8]  = '{0, 0, 0, 0, 0, 0, 1, 0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [49:0] mk(input int re, input int im);
    return {25'(re), 25'(im)};
  endfunction

  function automatic longint rnd(input longint x);
    longint y;
    y = x + 256;
    return (y >= 0) ? y / 512 : -((-y + 511) / 512);
  endfunction

  function automatic logic [32:0] model(input logic [49:0] w);
    longint a, b;
    logic   s;
    a = rnd(longint'($signed(w[49:25])));
    b = rnd(longint'($signed(w[24:0])));
    s = 1'b0;
    if (a > 32767) begin a = 32767; s = 1'b1; end
    else if (a < -32768) begin a = -32768; s = 1'b1; end
    if (b > 32767) begin b = 32767; s = 1'b1; end
    else if (b < -32768) begin b = -32768; s = 1'b1; end
    return {s, 16'(a), 16'(b)};
  endfunction

  task automatic ex(input bit l, input bit s, input int re, input int im);
    exp_q.push_back({l, s, 16'(re), 16'(im)});
  endtask

  // One cycle: drive inputs at the falling edge and score the handshakes of the coming rising edge
  task automatic tick(input bit v, input bit r);
    logic [33:0] e;
    @(negedge clk_i);
    valid_i  = v && src_q.size() > 0;
    signal_i = valid_i ? src_q[0] : '0;
    ready_i  = r;
    if (valid_o && ready_i) begin
      if (exp_q.size() == 0) chk("unexpected_valid", valid_o, 0);
      else begin
        e = exp_q.pop_front();
        chk("data", signal_o, e[31:0]);
        chk("last", last_o, e[33]);
        chk("sat", sat_o, e[32]);
      end
      outs++;
    end
    if (valid_i && ready_o) begin
      fbuf[in_cnt] = src_q.pop_front();
      acc++;
      if (in_cnt == 7) begin
        if (auto_exp) for (int k = 0; k < 8; k++) exp_q.push_back({k == 7, model(fbuf[ord[k]])});
        in_cnt = 0;
      end else in_cnt++;
    end
  endtask

  task automatic drain(input int v_pct, input int r_pct, input int bound);
    for (int i = 0; i < bound && (exp_q.size() > 0 || src_q.size() > 0 || valid_o); i++)
      tick($urandom_range(0, 99) < v_pct, $urandom_range(0, 99) < r_pct);
    chk("drain_exp", exp_q.size(), 0);
    chk("drain_src", src_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          changes, gaps, rdy_at;
    bit          seen;
    logic [31:0] held;
    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b0; signal_i = '0;
    repeat (2) @(negedge clk_i);
    chk("rst_valid", valid_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_sat", sat_o, 0);
    chk("rst_signal", signal_o, 0);
    chk("rst_ready", ready_o, 1);
    rst_ni = 1'b1;

    // Ramp frame: natural order out, last only on the 8th, one-cycle latency
    for (int n = 0; n < 8; n++) src_q.push_back(mk(n * 512, -n * 512));
    for (int i = 0; i < 8; i++) ex(i == 7, 0, ord[i], -ord[i]);
    repeat (8) tick(1, 1);
    tick(0, 1);
    chk("lat_pre", valid_o, 0);
    tick(0, 1);
    chk("lat_first", valid_o, 1);
    drain(100, 100, 100);

    // Rounding and saturation boundaries
    for (int n = 0; n < 8; n++) src_q.push_back(mk(ri[n], ii[n]));
    for (int i = 0; i < 8; i++) ex(i == 7, es[i], er[i], ei[i]);
    drain(100, 100, 100);

    // Backpressure: three frames offered while the output stalls
    auto_exp = 1;
    for (int f = 0; f < 3; f++) for (int n = 0; n < 8; n++) src_q.push_back(mk(1000 * f + 300 * n - 700, -50000 * f + 7 * n));
    acc = 0; changes = 0; seen = 0; held = '0;
    repeat (30) begin
      tick(1, 0);
      if (valid_o) begin
        if (!seen) begin held = signal_o; seen = 1; end
        else if (signal_o !== held) changes++;
      end
    end
    chk("bp_accepted", acc, 16);
    chk("bp_ready", ready_o, 0);
    chk("bp_valid", valid_o, 1);
    chk("bp_hold", changes, 0);
    chk("bp_first", signal_o, exp_q[0][31:0]);
    outs = 0; rdy_at = -1;
    for (int i = 0; i < 200 && (exp_q.size() > 0 || src_q.size() > 0); i++) begin
      tick(1, 1);
      if (rdy_at < 0 && ready_o) rdy_at = outs;
    end
    chk("bp_ready_rise", rdy_at, 8);
    chk("bp_outs", outs, 24);
    drain(100, 100, 50);

    // Continuous streaming: no output bubbles once the first frame is out
    for (int f = 0; f < 10; f++) for (int n = 0; n < 8; n++) src_q.push_back(mk(n * 4099 - f * 777777, f * 123457 - n * 999));
    outs = 0; gaps = 0; seen = 0;
    for (int i = 0; i < 300 && outs < 80; i++) begin
      tick(1, 1);
      if (valid_o) seen = 1;
      else if (seen) gaps++;
    end
    chk("stream_outs", outs, 80);
    chk("stream_gaps", gaps, 0);
    drain(100, 100, 50);

    // Random handshakes over 20 frames
    for (int n = 0; n < 160; n++)
      src_q.push_back(mk(int'($urandom_range(0, 33554431)) - 16777216, int'($urandom_range(0, 33554431)) - 16777216));
    drain(50, 50, 3000);

    // Asynchronous reset with frame 0 mid-output and 5 samples of frame 1 stored
    for (int n = 0; n < 13; n++) src_q.push_back(mk(n * 5000 - 30000, 20000 - n * 3000));
    repeat (13) tick(1, 1);
    tick(0, 0);
    chk("pre_rst_valid", valid_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_valid", valid_o, 0);
    chk("arst_ready", ready_o, 1);
    chk("arst_last", last_o, 0);
    chk("arst_signal", signal_o, 0);
    exp_q.delete(); src_q.delete(); in_cnt = 0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    for (int n = 0; n < 8; n++) src_q.push_back(mk(n * 1024 + 100, -n * 2048 - 300));
    drain(100, 100, 100);
    chk("post_rst_ready", ready_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fft_output_reorder.md
Name: fft_output_reorder

Overview:
- Last stage of the 8-point FFT pipeline. Sits directly downstream of fft_butterfly_stage3.
- Accepts 8-sample frames of packed complex results over a valid/ready stream.
- Buffers each frame in a ping-pong RAM and emits it in bit-reversed order (natural frequency order).
- Rounds and saturates each component from DATA_WIDTH/2 bits down to OUT_WIDTH/2 bits.

Parameters:
- DATA_WIDTH, 50, input word width: {re[DATA_WIDTH-1:DATA_WIDTH/2], im[DATA_WIDTH/2-1:0]}, both signed.
- OUT_WIDTH, 32, output word width: {re, im}, each OUT_WIDTH/2 bits signed. Must satisfy OUT_WIDTH < DATA_WIDTH, both even.
- FRAME, 8, samples per frame. Fixed at 8; the reorder logic is 3-bit.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- signal_i  in  DATA_WIDTH  packed complex sample from stage3.
- valid_i  in  1  signal_i valid.
- ready_o  out  1  block can accept a sample.
- signal_o  out  OUT_WIDTH  reordered, rounded sample.
- valid_o  out  1  signal_o valid.
- ready_i  in  1  downstream accepts.
- last_o  out  1  high with the 8th sample of each output frame.
- sat_o  out  1  high with any output sample in which either component saturated.

Behaviour:
- Reset: one clock (clk_i); reset is asynchronous and active-low (rst_ni). While rst_ni=0:
  - valid_o=0, last_o=0, sat_o=0, signal_o=0, ready_o=1.
  - wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0, both bank-full flags cleared.
  - RAM contents are not reset.
- Mid-operation reset: discards any partial or complete frames. After release, the next accepted sample is frame sample 0.
- Write side:
  - ready_o = !full[wr_bank]. Output is registered-state only, with no combinational path from ready_i.
  - On valid_i && ready_o: store signal_i at bank[wr_bank][wr_cnt], then increment wr_cnt.
  - When wr_cnt==7 is accepted: set full[wr_bank], toggle wr_bank, wr_cnt wraps to 0.
- Read side:
  - Output register loads when full[rd_bank] && (!valid_o || ready_i).
  - The loaded value is round(bank[rd_bank][bitrev3(rd_cnt)]). Read order is addresses 0,4,2,6,1,5,3,7.
  - On each load, rd_cnt increments. last_o is set when loading with rd_cnt==7.
  - On loading rd_cnt==7: clear full[rd_bank], toggle rd_bank, rd_cnt wraps to 0.
  - valid_o is cleared when ready_i && valid_o and no new load occurs.
  - signal_o, last_o and sat_o hold while valid_o && !ready_i.
- Simultaneous events: the write-side set of full[x] and the read-side clear of full[y] on the same edge both take effect. Since x≠y, no conflict arises.
- Rounding, per component x (IN_W=DATA_WIDTH/2, D=(DATA_WIDTH-OUT_WIDTH)/2):
  - y = (x + 2^(D-1)) >>> D, computed in IN_W+1 bits (round half up).
  - Saturate y to [-2^(OUT_WIDTH/2-1), 2^(OUT_WIDTH/2-1)-1].
  - sat_o = either component clipped.
- Latency: 8th input accepted at edge E → full set at E → first output (index 0) loaded at E+1, so valid_o=1 after edge E+1.
- Throughput: 1 sample/cycle sustained with ready_i=1. No bubbles between frames once the next bank is full.
- Backpressure: with both banks full, ready_o=0 until the read side frees a bank. ready_o rises on the edge that clears the bank.

Test Plan:
- Reset then frame in=0..7 (re=n·512, im=-n·512, D=9), ready_i=1:
  - Outputs re=0,4,2,6,1,5,3,7 and im=negated.
  - last_o only on the 8th output.
  - valid_o first high 1 cycle after the 8th input handshake.
- Rounding: re=767 (1.498·512) → 1; re=768 → 2; re=-768 → -1; re=2^24-1 → 32767 with sat_o=1.
- Backpressure: ready_i=0, push 3 frames back-to-back.
  - Expected: 16 accepted, then ready_o=0.
  - signal_o holds frame0 sample0 stable.
  - Release ready_i → 24 ordered outputs, with ready_o reasserting after the 8th output.
- Continuous streaming: 10 frames with valid_i=1 and ready_i=1 → no valid_o gaps after the first frame, all 80 outputs correct.
- Random valid_i/ready_i toggling (50%) over 20 frames: scoreboard confirms order and last_o placement.
- Assert rst_ni=0 after 5 samples of frame 1 and while frame 0 is mid-output:
  - valid_o=0 and ready_o=1 immediately (asynchronous).
  - Next frame outputs correctly from index 0.
